// File: rtl/range_pkg.sv
// range_pkg: shared FSM states, default word width and count-width helper for the range stream driver.
package range_pkg;
  localparam int RANGE_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_e;
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/range_tracker.sv
// range_tracker: running min/max over a word stream, reporting max-min.
module range_tracker
  import range_pkg::*;
#(
  parameter int WIDTH = RANGE_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             init,
  input  logic             update,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] span
);
  logic [WIDTH-1:0] min_q, min_d, max_q, max_d;
  always_comb begin
    min_d = init ? din : (update && din < min_q) ? din : min_q;
    max_d = init ? din : (update && din > max_q) ? din : max_q;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      min_q <= '0;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end
  assign span = max_q - min_q;
endmodule

// File: rtl/range_stream_driver.sv
// range_stream_driver: buffers host words, replays them as a go/finish framed stream and checks the returned range.
// Define RANGE_DRV_CHECK_EN to build the local max-min comparison; otherwise mismatch reflects error_in only.
module range_stream_driver
  import range_pkg::*;
#(
  parameter int WIDTH = RANGE_WIDTH,
  parameter int DEPTH = 8
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic [WIDTH-1:0]        load_data,
  input  logic                    start,
  input  logic [WIDTH-1:0]        range_in,
  input  logic                    error_in,
  output logic [WIDTH-1:0]        data_out,
  output logic                    go,
  output logic                    finish,
  output logic                    busy,
  output logic                    full,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                    done,
  output logic [WIDTH-1:0]        expected,
  output logic                    mismatch
);
  localparam int CW = cnt_w(DEPTH);
  localparam int IW = $clog2(DEPTH);
  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    count_q, count_d;
  logic             done_q, done_d, mismatch_q, mismatch_d;
  logic [WIDTH-1:0] expected_q, expected_d, span;
  logic [WIDTH-1:0] buf_q [DEPTH];
  logic             wr, sending, last, hit;
  assign sending = state_q == SEND;
  assign last    = {1'b0, idx_q} == count_q - CW'(1);
  assign full    = count_q == CW'(DEPTH);
`ifdef RANGE_DRV_CHECK_EN
  range_tracker #(.WIDTH(WIDTH)) u_tracker (
    .clock   (clock),
    .reset_n (reset_n),
    .init    (sending && idx_q == '0),
    .update  (sending),
    .din     (data_out),
    .span    (span)
  );
  assign hit = range_in != span;
`else
  logic unused_range;
  assign unused_range = ^range_in;
  assign span = '0;
  assign hit  = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    wr      = 1'b0;
    case (state_q)
      IDLE: begin
        wr      = load && !full;
        count_d = count_q + CW'(wr);
        if (start && count_d != '0) state_d = SEND;
      end
      SEND: begin
        idx_d = idx_q + 1'b1;
        if (last) state_d = WAIT;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        count_d = '0;
      end
    endcase
    done_d     = state_q == WAIT;
    expected_d = done_d ? span : expected_q;
    mismatch_d = done_d ? hit | error_in : mismatch_q;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      count_q    <= '0;
      done_q     <= 1'b0;
      expected_q <= '0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
      done_q     <= done_d;
      expected_q <= expected_d;
      mismatch_q <= mismatch_d;
    end
  end
  // Buffer contents survive reset; only count decides what is valid.
  always_ff @(posedge clock) begin
    if (wr) buf_q[count_q[IW-1:0]] <= load_data;
  end
  assign data_out = sending ? buf_q[idx_q] : '0;
  assign go       = sending && idx_q == '0;
  assign finish   = sending && last;
  assign busy     = state_q != IDLE;
  assign count    = count_q;
  assign done     = done_q;
  assign expected = expected_q;
  assign mismatch = mismatch_q;
endmodule

// File: tb/tb_range_stream_driver.sv
// tb_range_stream_driver: randomized self-checking bench with a queue-based reference model of the range stream driver.
module tb_range_stream_driver;
  localparam int DEPTH = 8;
  logic       clock = 1'b0, reset_n = 1'b0, load = 1'b0, start = 1'b0, error_in = 1'b0;
  logic [7:0] load_data = '0, range_in = '0;
  logic [7:0] data_out, expected;
  logic       go, finish, busy, full, done, mismatch;
  logic [3:0] count;
  int checks = 0, errors = 0;

  range_stream_driver #(.WIDTH(8), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .load(load), .load_data(load_data), .start(start),
    .range_in(range_in), .error_in(error_in), .data_out(data_out), .go(go), .finish(finish),
    .busy(busy), .full(full), .count(count), .done(done), .expected(expected), .mismatch(mismatch)
  );

  always #5 clock = ~clock;

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic load_words(input logic [7:0] w[$], output logic [7:0] acc[$]);
    int base;
    base = int'(count);
    acc = {};
    for (int i = 0; i < w.size(); i++) begin
      int want;
      load = 1'b1;
      load_data = w[i];
      cycle();
      want = (base + i + 1 > DEPTH) ? DEPTH : base + i + 1;
      if (base + i < DEPTH) acc.push_back(w[i]);
      checks++;
      if ({full, count} !== {want == DEPTH, 4'(want)}) begin
        errors++;
        $display("FAIL load %0d: full/count got %0b/%0d want %0b/%0d", i, full, count, want == DEPTH, want);
      end
    end
    load = 1'b0;
  endtask

  task automatic run_stream(input logic [7:0] w[$], input logic [7:0] rng, input bit err, input bit noise, input string tag);
    int n, mn, mx;
    logic [7:0] exp_rng;
    logic exp_mis;
    logic [10:0] got, want;
    n = w.size();
    mn = 255;
    mx = 0;
    foreach (w[i]) begin
      mn = (int'(w[i]) < mn) ? int'(w[i]) : mn;
      mx = (int'(w[i]) > mx) ? int'(w[i]) : mx;
    end
`ifdef RANGE_DRV_CHECK_EN
    exp_rng = 8'(mx - mn);
    exp_mis = (rng != exp_rng) || err;
`else
    exp_rng = '0;
    exp_mis = err;
`endif
    range_in = rng;
    error_in = err;
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (noise) begin
        load = 1'($urandom);
        load_data = 8'($urandom);
        start = 1'($urandom);
      end
      got = {data_out, go, finish, busy};
      want = {w[i], i == 0, i == n - 1, 1'b1};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s word %0d: data/go/finish/busy got %h want %h", tag, i, got, want);
      end
      cycle();
    end
    load = 1'b0;
    start = 1'b0;
    checks++;
    if ({data_out, go, finish, busy, done} !== {8'h0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL %s wait cycle: data=%h go=%b fin=%b busy=%b done=%b", tag, data_out, go, finish, busy, done);
    end
    cycle();
    checks++;
    if ({done, busy, count, expected, mismatch} !== {1'b1, 1'b0, 4'd0, exp_rng, exp_mis}) begin
      errors++;
      $display("FAIL %s done: done=%b busy=%b count=%0d exp=%0d mis=%b want exp=%0d mis=%b",
               tag, done, busy, count, expected, mismatch, exp_rng, exp_mis);
    end
    cycle();
    checks++;
    if ({done, expected, mismatch} !== {1'b0, exp_rng, exp_mis}) begin
      errors++;
      $display("FAIL %s hold: done=%b exp=%0d mis=%b want 0/%0d/%b", tag, done, expected, mismatch, exp_rng, exp_mis);
    end
  endtask

  task automatic test_reset();
    repeat (2) cycle();
    checks++;
    if ({data_out, go, finish, busy, full, count, done, expected, mismatch} !== '0) begin
      errors++;
      $display("FAIL reset: outputs got %h want 0", {data_out, go, finish, busy, full, count, done, expected, mismatch});
    end
    reset_n = 1'b1;
    cycle();
  endtask

  task automatic test_basic();
    logic [7:0] acc[$];
    load_words('{8'd3, 8'd9, 8'd5}, acc);
    run_stream(acc, 8'd6, 1'b0, 1'b0, "basic_match");
    load_words('{8'd3, 8'd9, 8'd5}, acc);
    run_stream(acc, 8'd7, 1'b0, 1'b0, "basic_miss");
  endtask

  task automatic test_single();
    logic [7:0] acc[$];
    load_words('{8'd42}, acc);
    run_stream(acc, 8'd0, 1'b0, 1'b0, "single");
  endtask

  task automatic test_full();
    logic [7:0] w[$], acc[$];
    for (int i = 0; i < DEPTH + 1; i++) w.push_back(8'($urandom));
    load_words(w, acc);
    run_stream(acc, 8'($urandom), 1'b0, 1'b1, "full");
  endtask

  task automatic test_empty_start();
    logic [7:0] acc[$];
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({go, busy, done} !== 3'b000) begin
        errors++;
        $display("FAIL empty_start %0d: go/busy/done got %b want 000", i, {go, busy, done});
      end
      cycle();
    end
    load_words('{8'd10, 8'd20}, acc);
    run_stream(acc, 8'd10, 1'b1, 1'b0, "error_flag");
  endtask

  task automatic test_load_start_same();
    load = 1'b1;
    start = 1'b1;
    load_data = 8'd77;
    range_in = 8'd0;
    error_in = 1'b0;
    cycle();
    load = 1'b0;
    start = 1'b0;
    checks++;
    if ({data_out, go, finish, busy} !== {8'd77, 1'b1, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL load_start: data/go/finish/busy got %h want %h", {data_out, go, finish, busy}, {8'd77, 3'b111});
    end
    repeat (2) cycle();
    checks++;
    if ({done, count} !== {1'b1, 4'd0}) begin
      errors++;
      $display("FAIL load_start done: done/count got %b/%0d want 1/0", done, count);
    end
    cycle();
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      logic [7:0] w[$], acc[$];
      int n, mn, mx;
      logic [7:0] rng;
      n = $urandom_range(1, DEPTH);
      mn = 255;
      mx = 0;
      for (int i = 0; i < n; i++) begin
        w.push_back(8'($urandom));
        mn = (int'(w[i]) < mn) ? int'(w[i]) : mn;
        mx = (int'(w[i]) > mx) ? int'(w[i]) : mx;
      end
      rng = $urandom_range(0, 1) ? 8'(mx - mn) : 8'($urandom);
      load_words(w, acc);
      run_stream(acc, rng, $urandom_range(0, 3) == 0, 1'b1, $sformatf("random%0d", t));
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] acc[$];
    load_words('{8'd1, 8'd2, 8'd3, 8'd4}, acc);
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({data_out, go, finish, busy} !== '0) begin
      errors++;
      $display("FAIL reset_mid: data/go/finish/busy got %h want 0", {data_out, go, finish, busy});
    end
    cycle();
    #2 reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      checks++;
      if ({done, busy, count} !== '0) begin
        errors++;
        $display("FAIL reset_mid after %0d: done/busy/count got %b/%b/%0d want 0/0/0", i, done, busy, count);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_full();
    test_empty_start();
    test_load_start_same();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
